multi_pulse_generator: RTL and testbench
========================================

// Module: multi_pulse_generator
// PURPOSE
//   Multi-channel, parametrised edge-to-pulse generator. Each channel watches one
//   level input, optionally synchronises it, and detects rising, falling or both
//   edges (selectable at run time). Each detected edge produces an output pulse of
//   programmable length, with optional retrigger. Used for CPU/peripheral event
//   triggering: timer kicks, IRQ strobes, debug-button pulses, async status lines.
// PARAMETERS
//   CHANNELS     4  number of independent channels (>=1)
//   SYNC_STAGES  2  input synchroniser flops per channel; 0 = input already synchronous
//   LEN_W        8  width of pulse_len_i and of the per-channel down-counter (>=1)
//   RETRIGGER    0  1: edge during active pulse reloads counter; 0: edge is dropped
// PORTS
//   clk_i         in   1               system clock
//   rst_ni        in   1               asynchronous, active-low reset
//   en_i          in   CHANNELS        level inputs, one bit per channel
//   mode_i        in   2*CHANNELS      per-channel edge mode, ch n at [2n+1:2n]
//   pulse_len_i   in   LEN_W           pulse length in cycles, shared by all channels
//   clr_drop_i    in   1               synchronous clear of drop_o (all channels)
//   pulse_o       out  CHANNELS        registered output pulses
//   drop_o        out  CHANNELS        sticky flag: an edge was ignored while busy
// BEHAVIOUR
//   - Reset (rst_ni=0, async): sync chain, edge-history reg, counters, pulse_o,
//     drop_o all 0 immediately. Mid-pulse reset aborts the pulse.
//     Release is used synchronously.
//   - Edge history resets to 0. An input already high at reset release is a rising
//     edge: it produces a pulse in MODE_RISE/BOTH.
//   - Modes: 00 OFF (no events), 01 RISE, 10 FALL, 11 BOTH.
//     event = matching edge between synchronised value s and history h (h <= s each cycle).
//   - Length L = pulse_len_i sampled on the event cycle; pulse_len_i==0 is treated as L=1.
//     Later changes to pulse_len_i do not affect a pulse in flight.
//   - Per-channel counter cnt (LEN_W bits). On event with cnt==0: cnt <= L. While cnt!=0: cnt <= cnt-1.
//     pulse_o is registered and equals (cnt != 0).
//   - Latency: en_i edge sampled at clock k -> pulse_o high from k+1+SYNC_STAGES,
//     high for exactly L cycles.
//     SYNC_STAGES=0, L=1 matches the legacy single-cycle rising-edge pulse.
//   - Event while cnt!=0:
//     RETRIGGER=1: cnt <= L; pulse stays high continuously, ending L cycles after the last event.
//     RETRIGGER=0: event ignored, drop_o[n] <= 1; the current pulse is unaffected.
//   - Event on the final cycle (cnt==1) counts as busy: it follows the rules above.
//     With RETRIGGER=0 the pulse ends and no gap-free continuation occurs.
//   - drop_o: sticky until clr_drop_i. If clr_drop_i and a new drop coincide, set wins.
//   - Changing mode_i mid-pulse (including to OFF) never truncates the active pulse.
//     It only gates future events. The history reg keeps tracking in OFF, so re-enabling
//     does not fire on stale edges.
//   - Channels are fully independent; simultaneous events on all channels are all honoured.
//   - Counter never wraps: decrement only when nonzero, load only at an event.
// STRUCTURE
//   - Shared package pulse_gen_pkg: localparams MODE_OFF=2'b00, MODE_RISE=2'b01,
//     MODE_FALL=2'b10, MODE_BOTH=2'b11; also the mode-field width.
//   - Sub-module pulse_channel: sync chain, history, edge/mode decode, counter, drop flag
//     for one channel. The top is a generate loop of CHANNELS instances plus port slicing.
//   - SYNC_STAGES==0 generate branch: s = en_i[n] directly.
// TESTING
//   1. CH=1, SYNC=0, L=1, RISE: en_i 0->1 at clk k, held -> pulse_o=1 only at k+1; no second pulse.
//   2. SYNC=2, L=5, FALL: en_i 1->0 -> pulse_o high cycles k+3..k+7 (5 cycles); rising edge -> nothing.
//   3. RETRIGGER=1, L=4, BOTH: edges 2 cycles apart x3 -> one continuous pulse,
//      low 4 cycles after the last event; drop_o=0.
//   4. RETRIGGER=0, L=4: second edge 2 cycles after the first -> pulse 4 cycles only,
//      drop_o=1 until clr_drop_i; clr and a new drop in the same cycle -> drop_o stays 1.
//   5. pulse_len_i=0 -> 1-cycle pulse. pulse_len_i=255 changed to 3 mid-pulse -> full 255 cycles.
//   6. Assert rst_ni mid-pulse (async, off-edge) -> pulse_o/drop_o 0 within the same cycle.
//      Release with en_i=1 in RISE mode -> pulse after 1+SYNC_STAGES cycles.
//      Mode OFF->RISE with en_i already high -> no pulse.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel edge-to-pulse generator:
// edge-mode encodings and the per-channel event decode.
package pulse_gen_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // s is the synchronised level, h its value one cycle earlier.
    function automatic logic edge_event(input mode_t mode, input logic s, input logic h);
        logic rise;
        logic fall;
        rise = s & ~h;
        fall = ~s & h;
        case (mode)
            MODE_RISE: edge_event = rise;
            MODE_FALL: edge_event = fall;
            MODE_BOTH: edge_event = rise | fall;
            default:   edge_event = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pulse_channel.sv
// One channel: optional synchroniser, edge history, mode-gated event decode,
// pulse-length down-counter and sticky drop flag.
module pulse_channel
    import pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = 8,
    parameter int RETRIGGER   = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  mode_t            mode_i,
    input  logic [LEN_W-1:0] pulse_len_i,
    input  logic             clr_drop_i,
    output logic             pulse_o,
    output logic             drop_o
);

    logic             s;
    logic             hist_q;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pulse_q;
    logic             drop_q, drop_d;
    logic             evt;
    logic             busy;
    logic             drop_set;
    logic [LEN_W-1:0] len_eff;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = en_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= en_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A zero length would never raise the pulse, so it is promoted to one cycle.
    assign len_eff = (pulse_len_i == '0) ? LEN_W'(1) : pulse_len_i;
    assign evt     = edge_event(mode_i, s, hist_q);
    assign busy    = (cnt_q != '0);

    always_comb begin
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        drop_set = 1'b0;
        if (evt && !busy) begin
            cnt_d = len_eff;
        end else if (evt && (RETRIGGER != 0)) begin
            cnt_d = len_eff;
        end else if (busy) begin
            cnt_d    = cnt_q - LEN_W'(1);
            drop_set = evt;
        end
        if (clr_drop_i) begin
            drop_d = 1'b0;
        end
        if (drop_set) begin
            drop_d = 1'b1;
        end
    end

    // History keeps tracking regardless of mode so re-enabling never fires on a stale edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q  <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            hist_q  <= s;
            cnt_q   <= cnt_d;
            pulse_q <= (cnt_d != '0);
            drop_q  <= drop_d;
        end
    end

    assign pulse_o = pulse_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel edge-to-pulse generator: one independent pulse_channel per
// level input, sharing the pulse length and the drop-clear strobe.
module multi_pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = 8,
    parameter int RETRIGGER   = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [CHANNELS-1:0]        en_i,
    input  logic [MODE_W*CHANNELS-1:0] mode_i,
    input  logic [LEN_W-1:0]           pulse_len_i,
    input  logic                       clr_drop_i,
    output logic [CHANNELS-1:0]        pulse_o,
    output logic [CHANNELS-1:0]        drop_o
);

    generate
        for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
            pulse_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .LEN_W       (LEN_W),
                .RETRIGGER   (RETRIGGER)
            ) u_ch (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .en_i        (en_i[n]),
                .mode_i      (mode_i[MODE_W*n +: MODE_W]),
                .pulse_len_i (pulse_len_i),
                .clr_drop_i  (clr_drop_i),
                .pulse_o     (pulse_o[n]),
                .drop_o      (drop_o[n])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator: three configurations on one clock
// (1ch/no-sync, 4ch/2-sync/no-retrigger, 1ch/2-sync/retrigger).
module tb_multi_pulse_generator;
    import pulse_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic [0:0] en0;   logic [1:0] mode0; logic [7:0] len0; logic clr0; logic [0:0] p0; logic [0:0] d0;
    logic [3:0] en1;   logic [7:0] mode1; logic [7:0] len1; logic clr1; logic [3:0] p1; logic [3:0] d1;
    logic [0:0] en2;   logic [1:0] mode2; logic [7:0] len2; logic clr2; logic [0:0] p2; logic [0:0] d2;

    multi_pulse_generator #(.CHANNELS(1), .SYNC_STAGES(0), .LEN_W(8), .RETRIGGER(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en0), .mode_i(mode0), .pulse_len_i(len0),
        .clr_drop_i(clr0), .pulse_o(p0), .drop_o(d0));

    multi_pulse_generator #(.CHANNELS(4), .SYNC_STAGES(2), .LEN_W(8), .RETRIGGER(0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .mode_i(mode1), .pulse_len_i(len1),
        .clr_drop_i(clr1), .pulse_o(p1), .drop_o(d1));

    multi_pulse_generator #(.CHANNELS(1), .SYNC_STAGES(2), .LEN_W(8), .RETRIGGER(1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .mode_i(mode2), .pulse_len_i(len2),
        .clr_drop_i(clr2), .pulse_o(p2), .drop_o(d2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        en0 = '0; mode0 = MODE_RISE; len0 = 8'd1; clr0 = 1'b0;
        en1 = '0; mode1 = {MODE_RISE, MODE_RISE, MODE_BOTH, MODE_FALL}; len1 = 8'd5; clr1 = 1'b0;
        en2 = '0; mode2 = MODE_BOTH; len2 = 8'd4; clr2 = 1'b0;

        #3;
        chk("rst_p0", 32'(p0), 0); chk("rst_d0", 32'(d0), 0);
        chk("rst_p1", 32'(p1), 0); chk("rst_d1", 32'(d1), 0);
        chk("rst_p2", 32'(p2), 0); chk("rst_d2", 32'(d2), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        // Legacy single-cycle rising-edge pulse, no synchroniser.
        en0 = 1'b1;
        tick(); chk("t1_first", 32'(p0), 1);
        tick(); chk("t1_end", 32'(p0), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t1_held", 32'(p0), 0);
        end

        // Falling-edge mode: rising edge ignored, falling edge gives 5 cycles.
        len1 = 8'd5;
        en1[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(); chk("t2_rise_ignored", 32'(p1[0]), 0);
        end
        en1[0] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick(); chk("t2_fall_pulse", 32'(p1[0]), 32'(i >= 3 && i <= 7));
        end

        // No retrigger: second edge while busy is dropped and flagged.
        len1 = 8'd4;
        en1[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t4_pulse", 32'(p1[1]), 32'(i >= 3 && i <= 6));
            chk("t4_drop", 32'(d1[1]), 32'(i >= 5));
            if (i == 2) en1[1] = 1'b0;
        end
        chk("t4_drop_vec", 32'(d1), 32'h2);
        tick(); chk("t4_drop_sticky", 32'(d1[1]), 1);
        clr1 = 1'b1;
        tick(); clr1 = 1'b0;
        chk("t4_drop_clr", 32'(d1[1]), 0);
        en1[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t4_set_wins", 32'(d1[1]), 32'(i >= 4));
            chk("t4_pulse2", 32'(p1[1]), 32'(i >= 3 && i <= 6));
            if (i == 1) en1[1] = 1'b0;
            if (i == 3) clr1 = 1'b1;
            if (i == 4) clr1 = 1'b0;
        end

        // Retrigger: three edges two cycles apart merge into one pulse.
        en2 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("t3_retrig", 32'(p2), 32'(i >= 3 && i <= 10));
            if (i == 2) en2 = 1'b0;
            if (i == 4) en2 = 1'b1;
        end
        chk("t3_nodrop", 32'(d2), 0);

        // Zero length is one cycle; a length change mid-pulse is ignored.
        len1 = 8'd0;
        en1[2] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(); chk("t5_len0", 32'(p1[2]), 32'(i == 3));
        end
        en1[2] = 1'b0;
        repeat (4) tick();
        len1 = 8'd255;
        en1[2] = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            tick();
            chk("t5_len255", 32'(p1[2]), 32'(i >= 3 && i <= 257));
            if (i == 5) len1 = 8'd3;
        end

        // Asynchronous reset mid-pulse, then release with inputs high.
        len1 = 8'd10;
        en1[3] = 1'b1;
        repeat (5) tick();
        chk("t6_pre_pulse", 32'(p1[3]), 1);
        chk("t6_pre_drop", 32'(d1[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_p1", 32'(p1), 0);
        chk("t6_rst_d1", 32'(d1), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("t6_rel_p1", 32'(p1), (i >= 3 && i <= 12) ? 32'hC : 32'h0);
            chk("t6_rel_p0", 32'(p0), 32'(i == 1));
            chk("t6_rel_p2", 32'(p2), 32'(i >= 3 && i <= 6));
            if (i == 5) mode1[7:6] = MODE_OFF;
        end

        // Enabling a mode with the input already high must not fire.
        mode1[1:0] = MODE_OFF;
        en1[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(); chk("t6_off", 32'(p1[0]), 0);
        end
        mode1[1:0] = MODE_RISE;
        for (int i = 1; i <= 6; i++) begin
            tick(); chk("t6_off_to_rise", 32'(p1), 0);
        end
        chk("t6_final_drop", 32'(d1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
